// File: rtl/vga_src_sequencer.sv
// Frame-synchronous source sequencer for the VGA demo datapath: drives the
// bar/gray mux selects and background colour from a manual setting or a slideshow table.
module vga_src_sequencer #(
    parameter int unsigned CD = 12,
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  run,
    input  logic [CD+1:0]         man_cfg,
    input  logic                  wr_en,
    input  logic [$clog2(N)-1:0]  wr_addr,
    input  logic [DW+CD+1:0]      wr_data,
    output logic                  bypass_bar,
    output logic                  bypass_gray,
    output logic [CD-1:0]         back_rgb,
    output logic [$clog2(N)-1:0]  cur_idx,
    output logic                  running
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = CD + 2;
    localparam int unsigned EW = DW + CW;

    // Cleared entry: zero dwell, both muxes bypassed, black background.
    localparam logic [EW-1:0] RST_ENTRY = {{DW{1'b0}}, 2'b11, {CD{1'b0}}};
    localparam logic [CW-1:0] RST_CFG   = {2'b11, {CD{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cfg_q, cfg_n;
    logic [DW-1:0]   cnt_q, cnt_n;
    logic [AW-1:0]   idx_q, idx_n;
    logic            running_q, running_n;
    logic [AW-1:0]   nxt_idx;
    logic [EW-1:0]   ld_entry;
    logic [EW-1:0]   table_q [N];

    // Slideshow table; loads read the pre-write contents on a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                table_q[i] <= RST_ENTRY;
            end
        end else if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output decode; everything only moves on frame_start.
    always_comb begin
        state_n   = state_q;
        cfg_n     = cfg_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        running_n = running_q;
        nxt_idx   = AW'(idx_q + AW'(1));
        ld_entry  = table_q[0];

        if (frame_start) begin
            case (state_q)
                IDLE: begin
                    idx_n = '0;
                    if (run) begin
                        ld_entry  = table_q[0];
                        state_n   = RUN;
                        cfg_n     = ld_entry[CW-1:0];
                        cnt_n     = ld_entry[EW-1:CW];
                        running_n = 1'b1;
                    end else begin
                        cfg_n = man_cfg;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_n   = IDLE;
                        cfg_n     = man_cfg;
                        idx_n     = '0;
                        running_n = 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_n = DW'(cnt_q - DW'(1));
                    end else begin
                        ld_entry = table_q[nxt_idx];
                        idx_n    = nxt_idx;
                        cfg_n    = ld_entry[CW-1:0];
                        cnt_n    = ld_entry[EW-1:CW];
                    end
                end
                default: begin
                    state_n   = IDLE;
                    running_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cfg_q     <= RST_CFG;
            cnt_q     <= '0;
            idx_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cfg_q     <= cfg_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            running_q <= running_n;
        end
    end

    assign bypass_bar  = cfg_q[CW-1];
    assign bypass_gray = cfg_q[CW-2];
    assign back_rgb    = cfg_q[CD-1:0];
    assign cur_idx     = idx_q;
    assign running     = running_q;

endmodule

// File: tb/tb_vga_src_sequencer.sv
// Directed bench for vga_src_sequencer: manual mode, slideshow stepping,
// live table writes, run drop, async reset and long dwell.
module tb_vga_src_sequencer;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic        run;
    logic [13:0] man_cfg;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [21:0] wr_data;
    logic        bypass_bar;
    logic        bypass_gray;
    logic [11:0] back_rgb;
    logic [1:0]  cur_idx;
    logic        running;

    int vectors;
    int miscompares;

    logic [13:0] obs_cfg;
    assign obs_cfg = {bypass_bar, bypass_gray, back_rgb};

    vga_src_sequencer #(.CD(12), .N(4), .DW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .run         (run),
        .man_cfg     (man_cfg),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bypass_bar  (bypass_bar),
        .bypass_gray (bypass_gray),
        .back_rgb    (back_rgb),
        .cur_idx     (cur_idx),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] mk(input logic [7:0] d, input logic b, input logic g,
                                       input logic [11:0] c);
        return {d, b, g, c};
    endfunction

    localparam logic [13:0] CFG_RST = {2'b11, 12'h000};
    localparam logic [13:0] CFG_MAN = {2'b01, 12'hF00};
    localparam logic [13:0] CFG_A   = {2'b01, 12'hA0A};
    localparam logic [13:0] CFG_B   = {2'b10, 12'hB0B};
    localparam logic [13:0] CFG_C   = {2'b00, 12'hC0C};
    localparam logic [13:0] CFG_D   = {2'b11, 12'hD0D};
    localparam logic [13:0] CFG_E   = {2'b00, 12'hE0E};
    localparam logic [13:0] CFG_F   = {2'b10, 12'hF0F};
    localparam logic [13:0] CFG_L   = {2'b01, 12'h5A5};
    localparam logic [13:0] CFG_M   = {2'b10, 12'h3C3};
    localparam logic [13:0] CFG_G   = {2'b00, 12'h123};

    // One frame_start pulse; outputs are sampled at the following negedge.
    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [21:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_cfg !== CFG_RST) begin
            miscompares++;
            $display("FAIL reset_cfg: got %h expected %h", obs_cfg, CFG_RST);
        end
        vectors++;
        if (cur_idx !== 2'd0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idx_run: got idx=%0d run=%b expected idx=0 run=0", cur_idx, running);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_manual();
        man_cfg = CFG_MAN;
        run     = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_cfg !== CFG_RST) begin
            miscompares++;
            $display("FAIL manual_before_pulse: got %h expected %h", obs_cfg, CFG_RST);
        end
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_MAN || running !== 1'b0 || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL manual_after_pulse: got cfg=%h run=%b idx=%0d expected cfg=%h run=0 idx=0",
                     obs_cfg, running, cur_idx, CFG_MAN);
        end
    endtask

    task automatic test_slideshow();
        logic [13:0] exp_cfg [10];
        logic [1:0]  exp_idx [10];
        exp_cfg = '{CFG_A, CFG_A, CFG_B, CFG_C, CFG_C, CFG_C, CFG_D, CFG_A, CFG_A, CFG_B};
        exp_idx = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        write_entry(2'd0, mk(8'd1, 1'b0, 1'b1, 12'hA0A));
        write_entry(2'd1, mk(8'd0, 1'b1, 1'b0, 12'hB0B));
        write_entry(2'd2, mk(8'd2, 1'b0, 1'b0, 12'hC0C));
        write_entry(2'd3, mk(8'd0, 1'b1, 1'b1, 12'hD0D));
        vectors++;
        if (obs_cfg !== CFG_MAN) begin
            miscompares++;
            $display("FAIL write_no_effect_idle: got %h expected %h", obs_cfg, CFG_MAN);
        end
        run = 1'b1;
        for (int f = 0; f < 10; f++) begin
            pulse_frame();
            vectors++;
            if (obs_cfg !== exp_cfg[f] || cur_idx !== exp_idx[f] || running !== 1'b1) begin
                miscompares++;
                $display("FAIL slideshow_frame%0d: got cfg=%h idx=%0d run=%b expected cfg=%h idx=%0d run=1",
                         f, obs_cfg, cur_idx, running, exp_cfg[f], exp_idx[f]);
            end
        end
    endtask

    task automatic test_write_during_run();
        logic [13:0] exp_cfg [4];
        logic [1:0]  exp_idx [4];
        exp_cfg = '{CFG_F, CFG_D, CFG_A, CFG_A};
        exp_idx = '{2'd2, 2'd3, 2'd0, 2'd0};
        write_entry(2'd1, mk(8'd0, 1'b0, 1'b0, 12'hE0E));
        write_entry(2'd2, mk(8'd0, 1'b1, 1'b0, 12'hF0F));
        vectors++;
        if (obs_cfg !== CFG_B || cur_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL live_write_hold: got cfg=%h idx=%0d expected cfg=%h idx=1", obs_cfg, cur_idx, CFG_B);
        end
        for (int f = 0; f < 4; f++) begin
            pulse_frame();
            vectors++;
            if (obs_cfg !== exp_cfg[f] || cur_idx !== exp_idx[f]) begin
                miscompares++;
                $display("FAIL live_write_frame%0d: got cfg=%h idx=%0d expected cfg=%h idx=%0d",
                         f, obs_cfg, cur_idx, exp_cfg[f], exp_idx[f]);
            end
        end
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_E || cur_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL live_write_new_entry1: got cfg=%h idx=%0d expected cfg=%h idx=1", obs_cfg, cur_idx, CFG_E);
        end
    endtask

    task automatic test_run_drop();
        pulse_frame();
        pulse_frame();
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_A || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL drop_setup: got cfg=%h idx=%0d expected cfg=%h idx=0", obs_cfg, cur_idx, CFG_A);
        end
        run = 1'b0;
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_MAN || cur_idx !== 2'd0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_to_idle: got cfg=%h idx=%0d run=%b expected cfg=%h idx=0 run=0",
                     obs_cfg, cur_idx, running, CFG_MAN);
        end
        run = 1'b1;
        pulse_frame();
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_A || cur_idx !== 2'd0 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_full_dwell: got cfg=%h idx=%0d run=%b expected cfg=%h idx=0 run=1",
                     obs_cfg, cur_idx, running, CFG_A);
        end
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_E || cur_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL restart_advance: got cfg=%h idx=%0d expected cfg=%h idx=1", obs_cfg, cur_idx, CFG_E);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (obs_cfg !== CFG_RST || cur_idx !== 2'd0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got cfg=%h idx=%0d run=%b expected cfg=%h idx=0 run=0",
                     obs_cfg, cur_idx, running, CFG_RST);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run     = 1'b1;
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_RST || cur_idx !== 2'd0 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_entry0: got cfg=%h idx=%0d run=%b expected cfg=%h idx=0 run=1",
                     obs_cfg, cur_idx, running, CFG_RST);
        end
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_RST || cur_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL post_reset_entry1: got cfg=%h idx=%0d expected cfg=%h idx=1", obs_cfg, cur_idx, CFG_RST);
        end
    endtask

    task automatic test_long_dwell();
        run = 1'b0;
        pulse_frame();
        write_entry(2'd0, mk(8'hFF, 1'b0, 1'b1, 12'h5A5));
        write_entry(2'd1, mk(8'h00, 1'b1, 1'b0, 12'h3C3));
        run = 1'b1;
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_L || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL long_first: got cfg=%h idx=%0d expected cfg=%h idx=0", obs_cfg, cur_idx, CFG_L);
        end
        repeat (255) pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_L || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL long_frame256: got cfg=%h idx=%0d expected cfg=%h idx=0", obs_cfg, cur_idx, CFG_L);
        end
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_M || cur_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL long_frame257: got cfg=%h idx=%0d expected cfg=%h idx=1", obs_cfg, cur_idx, CFG_M);
        end
    endtask

    task automatic test_same_cycle_write_load();
        run = 1'b0;
        pulse_frame();
        run = 1'b1;
        @(negedge clk);
        frame_start = 1'b1;
        wr_en       = 1'b1;
        wr_addr     = 2'd0;
        wr_data     = mk(8'd0, 1'b0, 1'b0, 12'h123);
        @(negedge clk);
        frame_start = 1'b0;
        wr_en       = 1'b0;
        vectors++;
        if (obs_cfg !== CFG_L || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL same_cycle_old: got cfg=%h idx=%0d expected cfg=%h idx=0", obs_cfg, cur_idx, CFG_L);
        end
        run = 1'b0;
        pulse_frame();
        run = 1'b1;
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_G || cur_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL same_cycle_new_next_load: got cfg=%h idx=%0d expected cfg=%h idx=0", obs_cfg, cur_idx, CFG_G);
        end
        pulse_frame();
        vectors++;
        if (obs_cfg !== CFG_M || cur_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL same_cycle_advance: got cfg=%h idx=%0d expected cfg=%h idx=1", obs_cfg, cur_idx, CFG_M);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        frame_start = 1'b0;
        run         = 1'b0;
        man_cfg     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;

        test_reset();
        test_manual();
        test_slideshow();
        test_write_during_run();
        test_run_drop();
        test_async_reset();
        test_long_dwell();
        test_same_cycle_write_load();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
